// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS run monitor: controller states and trace entry sizing.
package mips_mon_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RST_SEQ, S_RUN, S_DONE, S_TIMEOUT} state_t;

  // Packed trace entry is {reg addr, data}.
  function automatic int trace_entry_w(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/mips_trace_buf.sv
// Circular writeback trace: keeps the last DEPTH entries, read relative to the oldest.
module mips_trace_buf
  import mips_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int TW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [TW:0]   count,
  output logic          ovf,
  input  logic [TW-1:0] rd_idx,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int EW = trace_entry_w(AW, DW);
  localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic [EW-1:0] mem [DEPTH];
  logic [TW-1:0] wr_ptr, oldest, rd_ptr;
  entry_t        rd_e;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count == FULL) ovf <= 1'b1;
      else               count <= count + 1'b1;
    end
  end

  // Contents need no reset; count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {waddr, wdata};
  end

  // Once full, wr_ptr points at the oldest surviving entry.
  assign oldest  = (count < FULL) ? '0 : wr_ptr;
  assign rd_ptr  = oldest + rd_idx;
  assign rd_e    = entry_t'(mem[rd_ptr]);
  assign rd_addr = rd_e.addr;
  assign rd_data = rd_e.data;
endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for the MIPS core: reset sequencing, cycle/writeback counters,
// halt (PC self-loop) and timeout detection, plus a writeback trace.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int PC_WIDTH       = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_AW         = 5,
  parameter int RESET_CYCLES   = 4,
  parameter int HALT_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TRACE_DEPTH    = 16,
  localparam int TW            = $clog2(TRACE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  cpu_rst,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  running,
  output logic                  done,
  output logic                  timeout,
  output logic [31:0]           cycle_count,
  output logic [31:0]           wb_count,
  output logic [TW:0]           trace_count,
  output logic                  trace_ovf,
  input  logic [TW-1:0]         trace_idx,
  output logic [REG_AW-1:0]     trace_addr,
  output logic [DATA_WIDTH-1:0] trace_data
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int HW = $clog2(HALT_CYCLES);

  state_t                state;
  logic [RW-1:0]         rst_cnt;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  pc_vld;
  logic [HW-1:0]         same_cnt;
  logic                  new_run, wb_rec;

  assign new_run = start && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
  assign wb_rec  = (state == S_RUN) && wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      wb_count    <= '0;
      rst_cnt     <= '0;
      pc_q        <= '0;
      pc_vld      <= 1'b0;
      same_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (new_run) begin
            state       <= S_RST_SEQ;
            cpu_rst     <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            wb_count    <= '0;
            rst_cnt     <= '0;
            pc_vld      <= 1'b0;
            same_cnt    <= '0;
          end
        end
        S_RST_SEQ: begin
          if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
            running <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (wb_rec && wb_count != '1) wb_count <= wb_count + 1'b1;
          pc_q     <= pc_in;
          pc_vld   <= 1'b1;
          same_cnt <= (pc_vld && pc_in == pc_q) ? same_cnt + 1'b1 : '0;
          // same_cnt at HALT_CYCLES-1 means HALT_CYCLES identical samples already seen.
          if (same_cnt == HW'(HALT_CYCLES - 1)) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
            state   <= S_TIMEOUT;
            running <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mips_trace_buf #(
    .DEPTH (TRACE_DEPTH),
    .AW    (REG_AW),
    .DW    (DATA_WIDTH)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .clr     (new_run),
    .we      (wb_rec),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .count   (trace_count),
    .ovf     (trace_ovf),
    .rd_idx  (trace_idx),
    .rd_addr (trace_addr),
    .rd_data (trace_data)
  );
endmodule
